fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 155 +++++++++++++++
 tb/tb_fetch_stage.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, IF/ID register, and a four-state memory request FSM.
// Define FETCH_PERF_CNT_EN to add the fetch_count/flush_count performance counters.
module fetch_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        pcSrc,
  input  logic        jORb,
  input  logic        pcWrite,
  input  logic        ifidWrite,
  input  logic        ifidFlush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] INS,
  output logic [31:0] ID_pc4
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] flush_count
`endif
);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_HOLD, ST_DROP} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] imem_addr_q, imem_addr_d;
  logic        imem_req_q, imem_req_d;
  logic [31:0] ins_q, ins_d;
  logic [31:0] id_pc4_q, id_pc4_d;
  logic [31:0] hold_q, hold_d;
  logic [31:0] pc_plus4;
  logic [31:0] jump_target;
  logic [31:0] branch_target;
  logic [31:0] target;

  // Redirect targets are computed from the instruction currently sitting in IF/ID.
  always_comb begin
    pc_plus4      = pc_q + 32'd4;
    jump_target   = {id_pc4_q[31:28], ins_q[25:0], 2'b00};
    branch_target = id_pc4_q + {{14{ins_q[15]}}, ins_q[15:0], 2'b00};
    target        = jORb ? branch_target : jump_target;
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ins_d    = ins_q;
    id_pc4_d = id_pc4_q;
    hold_d   = hold_q;
    case (state_q)
      ST_IDLE: state_d = ST_REQ;
      ST_REQ: begin
        if (pcSrc) begin
          pc_d = target;
          if (imem_ready) begin
            ins_d = 32'h0;
          end else begin
            state_d = ST_DROP;
          end
        end else if (imem_ready) begin
          if (pcWrite && ifidWrite) begin
            ins_d    = imem_rdata;
            id_pc4_d = pc_plus4;
            pc_d     = pc_plus4;
          end else begin
            hold_d  = imem_rdata;
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (pcSrc) begin
          pc_d    = target;
          ins_d   = 32'h0;
          state_d = ST_REQ;
        end else if (pcWrite && ifidWrite) begin
          ins_d    = hold_q;
          id_pc4_d = pc_plus4;
          pc_d     = pc_plus4;
          state_d  = ST_REQ;
        end
      end
      ST_DROP: begin
        // The in-flight word belongs to the old path; only the PC may move here.
        if (pcSrc) pc_d = target;
        if (imem_ready) state_d = ST_REQ;
      end
      default: state_d = ST_IDLE;
    endcase
    if (ifidFlush) begin
      ins_d    = 32'h0;
      id_pc4_d = id_pc4_q;
    end
    imem_req_d  = (state_d == ST_REQ) || (state_d == ST_DROP);
    imem_addr_d = (state_d == ST_REQ) ? pc_d : imem_addr_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pc_q        <= 32'h0;
      imem_addr_q <= 32'h0;
      imem_req_q  <= 1'b0;
      ins_q       <= 32'h0;
      id_pc4_q    <= 32'h0;
      hold_q      <= 32'h0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      imem_addr_q <= imem_addr_d;
      imem_req_q  <= imem_req_d;
      ins_q       <= ins_d;
      id_pc4_q    <= id_pc4_d;
      hold_q      <= hold_d;
    end
  end

  assign imem_req  = imem_req_q;
  assign imem_addr = imem_addr_q;
  assign INS       = ins_q;
  assign ID_pc4    = id_pc4_q;

`ifdef FETCH_PERF_CNT_EN
  logic        data_avail;
  logic        fetch_inc;
  logic        flush_inc;
  logic [31:0] fetch_count_q, fetch_count_d;
  logic [31:0] flush_count_q, flush_count_d;

  // A word is available from memory in REQ or from the hold buffer in HOLD.
  always_comb begin
    data_avail    = ((state_q == ST_REQ) && imem_ready) || (state_q == ST_HOLD);
    fetch_inc     = data_avail && !pcSrc && !ifidFlush && pcWrite && ifidWrite;
    flush_inc     = ifidFlush || (data_avail && pcSrc);
    fetch_count_d = fetch_count_q + {31'h0, fetch_inc};
    flush_count_d = flush_count_q + {31'h0, flush_inc};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_count_q <= 32'h0;
      flush_count_q <= 32'h0;
    end else begin
      fetch_count_q <= fetch_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign fetch_count = fetch_count_q;
  assign flush_count = flush_count_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vectors with a request-address scoreboard.
// Counter checks are compiled in only when FETCH_PERF_CNT_EN is defined.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        pcSrc, jORb, pcWrite, ifidWrite, ifidFlush;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] INS, ID_pc4;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count, flush_count;
`endif

  int checks   = 0;
  int failures = 0;
  logic [31:0] addrQ[$];

  fetch_stage dut (
    .clk(clk), .rst(rst), .pcSrc(pcSrc), .jORb(jORb), .pcWrite(pcWrite),
    .ifidWrite(ifidWrite), .ifidFlush(ifidFlush), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .INS(INS), .ID_pc4(ID_pc4)
`ifdef FETCH_PERF_CNT_EN
    , .fetch_count(fetch_count), .flush_count(flush_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs; optionally queue the address the handshake must show.
  task automatic applyStimulus(input logic src, input logic jb, input logic pw, input logic iw,
                               input logic fl, input logic rdy, input logic [31:0] rd,
                               input logic hs, input logic [31:0] expAddr);
    pcSrc = src; jORb = jb; pcWrite = pw; ifidWrite = iw; ifidFlush = fl;
    imem_ready = rdy; imem_rdata = rd;
    if (hs) addrQ.push_back(expAddr);
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted memory request pops one expected address.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && imem_req === 1'b1 && imem_ready === 1'b1) begin
        if (addrQ.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpectedHandshake: got addr %h expected no request", imem_addr);
        end else begin
          checkOutput("handshakeAddr", imem_addr, addrQ.pop_front());
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    pcSrc = 0; jORb = 0; pcWrite = 1; ifidWrite = 1; ifidFlush = 0;
    imem_ready = 1; imem_rdata = 32'hDEAD0000;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("resetReq", {31'h0, imem_req}, 32'h0);
    checkOutput("resetAddr", imem_addr, 32'h0);
    checkOutput("resetIns", INS, 32'h0);
    checkOutput("resetPc4", ID_pc4, 32'h0);
    rst = 1'b0;

    // IDLE cycle ignores the ready pulse, then sequential fetches 0,4,8
    applyStimulus(0, 0, 1, 1, 0, 1, 32'hDEADBEEF, 0, 0);
    checkOutput("idleIgnoresReady", INS, 32'h0);
    checkOutput("firstReq", {31'h0, imem_req}, 32'h1);
    checkOutput("firstAddr", imem_addr, 32'h0);
    applyStimulus(0, 0, 1, 1, 0, 1, 32'h11110000, 1, 32'h0);
    checkOutput("seqIns0", INS, 32'h11110000);
    checkOutput("seqPc4_0", ID_pc4, 32'h4);
    applyStimulus(0, 0, 1, 1, 0, 1, 32'h11110004, 1, 32'h4);
    checkOutput("seqIns1", INS, 32'h11110004);
    applyStimulus(0, 0, 1, 1, 0, 1, 32'h11110008, 1, 32'h8);
    checkOutput("seqIns2", INS, 32'h11110008);
    checkOutput("seqAddr", imem_addr, 32'hC);

    // Stall during data return: HOLD for three cycles, then release
    applyStimulus(0, 0, 0, 0, 0, 1, 32'h2222000C, 1, 32'hC);
    checkOutput("holdReq", {31'h0, imem_req}, 32'h0);
    checkOutput("holdIns", INS, 32'h11110008);
    applyStimulus(0, 0, 0, 0, 0, 1, 32'hBAD00001, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 32'hBAD00002, 0, 0);
    checkOutput("holdInsFrozen", INS, 32'h11110008);
    checkOutput("holdReqStill", {31'h0, imem_req}, 32'h0);
    applyStimulus(0, 0, 1, 1, 0, 0, 32'h0, 0, 0);
    checkOutput("releaseIns", INS, 32'h2222000C);
    checkOutput("releasePc4", ID_pc4, 32'h10);
    checkOutput("releaseAddr", imem_addr, 32'h10);

    // Jump to 0x00400004, then the jump 0x08000010 with ID_pc4 0x00400008
    applyStimulus(0, 0, 1, 1, 0, 1, 32'h08100001, 1, 32'h10);
    applyStimulus(1, 0, 1, 1, 0, 1, 32'hBADBAD01, 1, 32'h14);
    checkOutput("jump1Addr", imem_addr, 32'h00400004);
    checkOutput("jump1Nop", INS, 32'h0);
    checkOutput("jump1Pc4Kept", ID_pc4, 32'h14);
    applyStimulus(0, 0, 1, 1, 0, 1, 32'h08000010, 1, 32'h00400004);
    checkOutput("jump2Pc4", ID_pc4, 32'h00400008);
    applyStimulus(1, 0, 1, 1, 0, 1, 32'hBADBAD02, 1, 32'h00400008);
    checkOutput("jump2Addr", imem_addr, 32'h40);
    checkOutput("jump2Nop", INS, 32'h0);

    // Reach 0xFC, load branch imm FFFE (ID_pc4 0x100), redirect with no data -> DROP
    applyStimulus(0, 0, 1, 1, 0, 1, 32'h0800003F, 1, 32'h40);
    applyStimulus(1, 0, 1, 1, 0, 1, 32'hBADBAD03, 1, 32'h44);
    checkOutput("jump3Addr", imem_addr, 32'hFC);
    applyStimulus(0, 0, 1, 1, 0, 1, 32'h1000FFFE, 1, 32'hFC);
    checkOutput("branchPc4", ID_pc4, 32'h100);
    applyStimulus(1, 1, 1, 1, 0, 0, 32'h0, 0, 0);
    checkOutput("dropReq", {31'h0, imem_req}, 32'h1);
    checkOutput("dropOldAddr", imem_addr, 32'h100);
    applyStimulus(0, 0, 1, 1, 0, 0, 32'h0, 0, 0);
    checkOutput("dropWaitAddr", imem_addr, 32'h100);
    applyStimulus(0, 0, 1, 1, 0, 1, 32'hBADBAD04, 1, 32'h100);
    checkOutput("dropNextAddr", imem_addr, 32'hF8);
    checkOutput("dropDiscard", INS, 32'h1000FFFE);
    applyStimulus(0, 0, 1, 1, 0, 1, 32'h333300F8, 1, 32'hF8);
    checkOutput("afterDropIns", INS, 32'h333300F8);

    // ifidFlush beats ifidWrite: INS becomes NOP, ID_pc4 held
    applyStimulus(0, 0, 1, 1, 1, 1, 32'h444400FC, 1, 32'hFC);
    checkOutput("flushIns", INS, 32'h0);
    checkOutput("flushPc4", ID_pc4, 32'hFC);

    // Branch to 0xFFFFFFFC, then PC+4 wraps to 0
    applyStimulus(0, 0, 1, 1, 0, 1, 32'h1000FFBE, 1, 32'h100);
    applyStimulus(1, 1, 1, 1, 0, 1, 32'hBADBAD05, 1, 32'h104);
    checkOutput("wrapTarget", imem_addr, 32'hFFFFFFFC);
    applyStimulus(0, 0, 1, 1, 0, 1, 32'h55550000, 1, 32'hFFFFFFFC);
    checkOutput("wrapPc4", ID_pc4, 32'h0);
    checkOutput("wrapAddr", imem_addr, 32'h0);

    // Reset while a request is outstanding
    applyStimulus(0, 0, 1, 1, 0, 0, 32'h0, 0, 0);
    rst = 1'b1;
    imem_ready = 1'b1;
    imem_rdata = 32'hBADBAD06;
    #2;
    checkOutput("midResetReq", {31'h0, imem_req}, 32'h0);
    checkOutput("midResetIns", INS, 32'h0);
    checkOutput("midResetPc4", ID_pc4, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(0, 0, 1, 1, 0, 1, 32'hBADBAD07, 0, 0);
    checkOutput("postResetIns", INS, 32'h0);
    checkOutput("postResetAddr", imem_addr, 32'h0);
    applyStimulus(0, 0, 1, 1, 0, 1, 32'h66660000, 1, 32'h0);
    checkOutput("postResetFetch", INS, 32'h66660000);

    // Nine more fetches, then two flush-only cycles
    for (int i = 1; i <= 9; i++) begin
      applyStimulus(0, 0, 1, 1, 0, 1, 32'h66660000 + 32'(4 * i), 1, 32'(4 * i));
    end
    checkOutput("loopIns", INS, 32'h66660024);
    applyStimulus(0, 0, 1, 1, 1, 0, 32'h0, 0, 0);
    applyStimulus(0, 0, 1, 1, 1, 0, 32'h0, 0, 0);
    checkOutput("loopFlushIns", INS, 32'h0);
    checkOutput("loopFlushPc4", ID_pc4, 32'h28);
`ifdef FETCH_PERF_CNT_EN
    checkOutput("fetchCount", fetch_count, 32'd10);
    checkOutput("flushCount", flush_count, 32'd2);
`endif

    applyStimulus(0, 0, 1, 1, 0, 0, 32'h0, 0, 0);
    checkOutput("addrQueueEmpty", 32'(addrQ.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
